// File: rtl/turtle_clk_pkg.sv
// Shared types and constants for the clock-step front-end.
package turtle_clk_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESS_WAIT,
        BTN_PRESSED,
        BTN_RELEASE_WAIT
    } btn_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous control bit; resets to 0.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_step_controller.sv
// Turns the manual switch and step button into a one-cycle CPU advance enable,
// either one per debounced press (manual) or a divided free-running enable (run).
module clock_step_controller
    import turtle_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned RUN_DIVIDE      = 100,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   manual_clk_sw,
    input  logic                   pulse_clk_btn,
    output logic                   cpu_clk_en,
    output logic                   manual_mode,
    output logic [COUNT_WIDTH-1:0] step_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DIV_W = $clog2(RUN_DIVIDE + 1);
    // The wait states exit on the edge that would bump cnt to DEBOUNCE_CYCLES-1,
    // so the debounce window spans exactly DEBOUNCE_CYCLES stable samples.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIVIDE - 1);

    logic sw_s;
    logic btn_s;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sw_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (manual_clk_sw),
        .q_o    (sw_s)
    );

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_btn_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (pulse_clk_btn),
        .q_o    (btn_s)
    );

    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   en_q, en_d;
    logic [COUNT_WIDTH-1:0] step_q, step_d;
    logic                   press_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        unique case (state_q)
            BTN_IDLE: begin
                if (btn_s) begin
                    state_d = BTN_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            BTN_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = BTN_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = BTN_PRESSED;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BTN_PRESSED: begin
                if (!btn_s) begin
                    state_d = BTN_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            BTN_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = BTN_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = BTN_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = BTN_IDLE;
        endcase
    end

    always_comb begin
        if (sw_s) begin
            div_d = '0;
            en_d  = press_evt;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            en_d  = (div_q == DIV_LAST);
        end
        step_d = en_q ? step_q + COUNT_WIDTH'(1) : step_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            en_q    <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            en_q    <= en_d;
            step_q  <= step_d;
        end
    end

    assign cpu_clk_en  = en_q;
    assign manual_mode = sw_s;
    assign step_count  = step_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Scoreboard bench: each scenario pushes the cycle numbers at which an enable
// must appear; a monitor pops and compares whenever cpu_clk_en is seen.
module tb_clock_step_controller;

    localparam int unsigned D  = 4;
    localparam int unsigned R  = 3;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sw;
    logic          btn;
    logic          en;
    logic          mm;
    logic [CW-1:0] sc;

    int cyc = 0;
    int sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int exp_steps = 0;

    clock_step_controller #(
        .DEBOUNCE_CYCLES (D),
        .RUN_DIVIDE      (R),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .manual_clk_sw (sw),
        .pulse_clk_btn (btn),
        .cpu_clk_en    (en),
        .manual_mode   (mm),
        .step_count    (sc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0] < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL enable_missing: got none at cycle %0d, want enable there", sb[0]);
                void'(sb.pop_front());
            end
            if (en === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL enable_unexpected: got enable at cycle %0d, want none", cyc);
                end else if (sb[0] !== cyc) begin
                    n_bad++;
                    $display("FAIL enable_timing: got enable at cycle %0d, want cycle %0d", cyc, sb[0]);
                end else begin
                    void'(sb.pop_front());
                end
            end else if (en !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL enable_unknown: got %b at cycle %0d, want 0/1", en, cyc);
            end
        end
    endtask

    task automatic check_end(input string name);
        n_cmp++;
        if (sc !== CW'(exp_steps)) begin
            n_bad++;
            $display("FAIL %s_step_count: got %0d, want %0d", name, sc, CW'(exp_steps));
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_pending: got %0d enables outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic press_hold(input int hold, input int low);
        int k;
        @(posedge clk); #1;
        k = cyc;
        btn = 1'b1;
        sb.push_back(k + 2 + D);
        exp_steps++;
        wait_cycles(hold);
        btn = 1'b0;
        wait_cycles(low);
    endtask

    task automatic test_reset();
        int k;
        reset_n = 1'b0;
        sw      = 1'b1;
        btn     = 1'b1;
        wait_cycles(3);
        @(negedge clk);
        n_cmp++;
        if (en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b, want 0", en); end
        n_cmp++;
        if (mm !== 1'b0) begin n_bad++; $display("FAIL reset_mode: got %b, want 0", mm); end
        n_cmp++;
        if (sc !== '0) begin n_bad++; $display("FAIL reset_count: got %0d, want 0", sc); end
        @(posedge clk); #1;
        k = cyc;
        reset_n = 1'b1;
        sb.push_back(k + 2 + D);
        exp_steps++;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mm !== 1'b0) begin n_bad++; $display("FAIL reset_mode_early: got %b, want 0", mm); end
        @(negedge clk);
        n_cmp++;
        if (mm !== 1'b1) begin n_bad++; $display("FAIL reset_mode_rise: got %b, want 1", mm); end
        wait_cycles(15);
        btn = 1'b0;
        wait_cycles(20);
        check_end("reset");
    endtask

    task automatic test_clean_press();
        press_hold(20, 20);
        check_end("clean_press");
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        logic [2:0] rel;
        int k;
        pat = 8'b1011_1011;
        rel = 3'b100;
        @(posedge clk); #1;
        k = cyc;
        sb.push_back(k + 7 + 2 + D);
        exp_steps++;
        for (int i = 0; i < 8; i++) begin
            btn = pat[i];
            wait_cycles(1);
        end
        wait_cycles(20);
        for (int i = 0; i < 3; i++) begin
            btn = rel[i];
            wait_cycles(1);
        end
        wait_cycles(5);
        btn = 1'b0;
        wait_cycles(20);
        check_end("bounce");
    endtask

    task automatic test_run_mode();
        int k;
        @(posedge clk); #1;
        k = cyc;
        sw = 1'b0;
        for (int i = 0; i < 10; i++) sb.push_back(k + 5 + 3 * i);
        exp_steps += 10;
        wait_cycles(3);
        btn = 1'b1;
        wait_cycles(10);
        btn = 1'b0;
        wait_cycles(19);
        sw = 1'b1;
        wait_cycles(12);
        n_cmp++;
        if (mm !== 1'b1) begin n_bad++; $display("FAIL run_back_to_manual: got %b, want 1", mm); end
        check_end("run_mode");
    endtask

    task automatic test_mode_switch();
        int k;
        @(posedge clk); #1;
        k = cyc;
        sw = 1'b0;
        sb.push_back(k + 5);
        exp_steps++;
        wait_cycles(4);
        sw = 1'b1;
        wait_cycles(15);
        check_end("mode_switch_mid");
        press_hold(20, 20);
        check_end("mode_switch_press");
    endtask

    task automatic test_wrap();
        int k;
        @(posedge clk); #1;
        reset_n   = 1'b0;
        sw        = 1'b0;
        btn       = 1'b0;
        exp_steps = 0;
        @(negedge clk);
        n_cmp++;
        if (sc !== '0) begin n_bad++; $display("FAIL wrap_reset_count: got %0d, want 0", sc); end
        wait_cycles(2);
        k = cyc;
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) sb.push_back(k + 3 + 3 * i);
        wait_cycles(49);
        @(negedge clk);
        n_cmp++;
        if (sc !== '0) begin n_bad++; $display("FAIL wrap_at_16: got %0d, want 0", sc); end
        @(posedge clk); #1;
        sw = 1'b1;
        exp_steps = 17;
        wait_cycles(12);
        check_end("wrap");
    endtask

    initial begin
        reset_n = 1'b0;
        sw      = 1'b1;
        btn     = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_clean_press();
        test_bounce();
        test_run_mode();
        test_mode_switch();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
